// File: rtl/rice_core_pkg.sv
// Shared types for the rice core instruction-fetch path.
package rice_core_pkg;

   localparam int unsigned RICE_XLEN = 64;
   localparam int unsigned RICE_ILEN = 32;

   // Instruction response as carried through the fetch response FIFO.
   typedef struct packed {
      logic                 error;
      logic [RICE_ILEN-1:0] data;
   } rice_core_inst_response;

endpackage

// File: rtl/rice_core_inst_response_fifo.sv
// In-order response FIFO with synchronous clear and occupancy count.
module rice_core_inst_response_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 33,
   localparam int unsigned CW = $clog2(DEPTH + 1),
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
      return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   // A pop at full frees the slot the push lands in, so full push+pop is legal.
   assign do_pop  = pop & (count != '0);
   assign do_push = push & ((count != CW'(DEPTH)) | do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/rice_core_inst_responder.sv
// Fetch-request responder: credit-limited acks, one-cycle synchronous memory read,
// in-order responses through a small FIFO, flush discards everything pending.
module rice_core_inst_responder
   import rice_core_pkg::*;
#(
   parameter int unsigned XLEN       = RICE_XLEN,
   parameter int unsigned ILEN       = RICE_ILEN,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DEPTH      = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_inst_request_valid,
   output logic                  o_inst_request_ack,
   input  logic [XLEN-1:0]       i_inst_request_address,
   output logic                  o_mem_read,
   output logic [ADDR_WIDTH-1:0] o_mem_address,
   input  logic [ILEN-1:0]       i_mem_data,
   output logic                  o_inst_response_valid,
   input  logic                  i_inst_response_ready,
   output logic [ILEN-1:0]       o_inst_response_data,
   output logic                  o_inst_response_error,
   input  logic                  i_flush
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned RW = $bits(rice_core_inst_response);

   logic                   s1_valid;
   logic                   s1_error;
   logic [CW-1:0]          fifo_count;
   logic [RW-1:0]          fifo_rdata;
   logic                   fifo_empty;
   logic [CW:0]            outstanding;
   logic                   credit_ok;
   logic                   addr_error;
   logic                   ack;
   logic                   pop;
   logic                   push;
   logic                   fifo_pop;
   logic                   resp_valid;
   rice_core_inst_response s1_resp;
   rice_core_inst_response head;

   assign addr_error = (|i_inst_request_address[1:0])
                     | (|i_inst_request_address[XLEN-1:ADDR_WIDTH+2]);

   assign outstanding = {1'b0, fifo_count} + (CW + 1)'(s1_valid);
   assign credit_ok   = (outstanding - (CW + 1)'(pop)) < (CW + 1)'(DEPTH);

   // Reset gates the ack so no read strobe escapes while the block is held in reset.
   assign ack = i_rst_n & i_inst_request_valid & ~i_flush & credit_ok;

   assign o_inst_request_ack = ack;
   assign o_mem_read         = ack & ~addr_error;
   assign o_mem_address      = i_inst_request_address[ADDR_WIDTH+1:2];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_valid <= 1'b0;
         s1_error <= 1'b0;
      end else begin
         s1_valid <= ack;
         s1_error <= ack & addr_error;
      end
   end

   always_comb begin
      s1_resp       = '0;
      s1_resp.error = s1_error;
      s1_resp.data  = s1_error ? '0 : i_mem_data;
   end

   // With an empty FIFO the stage-1 word is presented directly, giving one-cycle latency;
   // if it is not taken it enters the FIFO and stays at the head unchanged.
   assign fifo_empty = (fifo_count == '0);
   assign resp_valid = ~fifo_empty | s1_valid;
   assign head       = fifo_empty ? s1_resp : rice_core_inst_response'(fifo_rdata);
   assign pop        = resp_valid & i_inst_response_ready;
   assign fifo_pop   = pop & ~fifo_empty;
   assign push       = s1_valid & ~i_flush & ~(fifo_empty & i_inst_response_ready);

   assign o_inst_response_valid = resp_valid;
   assign o_inst_response_data  = resp_valid ? head.data : '0;
   assign o_inst_response_error = resp_valid & head.error;

   rice_core_inst_response_fifo #(
      .DEPTH(DEPTH),
      .WIDTH(RW)
   ) u_fifo (
      .clk  (i_clk),
      .rst_n(i_rst_n),
      .push (push),
      .pop  (fifo_pop),
      .clear(i_flush),
      .wdata(s1_resp),
      .rdata(fifo_rdata),
      .count(fifo_count)
   );

endmodule

// File: tb/tb_rice_core_inst_responder.sv
// Directed bench for rice_core_inst_responder with a synchronous-read memory model.
module tb_rice_core_inst_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ack;
   logic [63:0] req_addr;
   logic        mem_read;
   logic [9:0]  mem_address;
   logic [31:0] mem_data;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic        resp_error;
   logic        flush;

   logic [31:0] mem [1024];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   // Synchronous-read memory; garbage when no read so dropped/suppressed reads show up.
   always @(posedge clk) mem_data <= mem_read ? mem[mem_address] : 32'hBAD0_BAD0;

   rice_core_inst_responder dut (
      .i_clk                 (clk),
      .i_rst_n               (rst_n),
      .i_inst_request_valid  (req_valid),
      .o_inst_request_ack    (req_ack),
      .i_inst_request_address(req_addr),
      .o_mem_read            (mem_read),
      .o_mem_address         (mem_address),
      .i_mem_data            (mem_data),
      .o_inst_response_valid (resp_valid),
      .i_inst_response_ready (resp_ready),
      .o_inst_response_data  (resp_data),
      .o_inst_response_error (resp_error),
      .i_flush               (flush)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [63:0] a, input logic r, input logic f);
      @(negedge clk);
      req_valid  = v;
      req_addr   = a;
      resp_ready = r;
      flush      = f;
      #1;
   endtask

   task automatic check_resp(input string tag, input logic [31:0] d, input logic e);
      check({tag, "_valid"}, 64'(resp_valid), 64'd1);
      check({tag, "_data"}, 64'(resp_data), 64'(d));
      check({tag, "_error"}, 64'(resp_error), 64'(e));
   endtask

   task automatic single_fetch(input string tag);
      drive(1'b1, 64'h100, 1'b1, 1'b0);
      check({tag, "_ack"}, 64'(req_ack), 64'd1);
      check({tag, "_rd"}, 64'(mem_read), 64'd1);
      check({tag, "_addr"}, 64'(mem_address), 64'h40);
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      check_resp({tag, "_resp"}, 32'h0000_0013, 1'b0);
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      check({tag, "_idle"}, 64'(resp_valid), 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_0000 | i;
      mem[0]    = 32'h1111_1111;
      mem[1]    = 32'h2222_2222;
      mem[2]    = 32'h3333_3333;
      mem[3]    = 32'h4444_4444;
      mem[8]    = 32'h8888_8888;
      mem[10'h40] = 32'h0000_0013;

      rst_n      = 1'b0;
      req_valid  = 1'b1;
      req_addr   = 64'h100;
      resp_ready = 1'b1;
      flush      = 1'b0;
      #1;
      check("rst_ack", 64'(req_ack), 64'd0);
      check("rst_rd", 64'(mem_read), 64'd0);
      check("rst_valid", 64'(resp_valid), 64'd0);
      check("rst_data", 64'(resp_data), 64'd0);
      repeat (2) drive(1'b0, 64'h0, 1'b1, 1'b0);
      rst_n = 1'b1;

      single_fetch("single");

      // Back-to-back streaming
      drive(1'b1, 64'h0, 1'b1, 1'b0);
      check("strm_ack0", 64'(req_ack), 64'd1);
      drive(1'b1, 64'h4, 1'b1, 1'b0);
      check("strm_ack1", 64'(req_ack), 64'd1);
      check_resp("strm_r0", 32'h1111_1111, 1'b0);
      drive(1'b1, 64'h8, 1'b1, 1'b0);
      check("strm_ack2", 64'(req_ack), 64'd1);
      check_resp("strm_r1", 32'h2222_2222, 1'b0);
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      check_resp("strm_r2", 32'h3333_3333, 1'b0);
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      check("strm_idle", 64'(resp_valid), 64'd0);

      // Backpressure: only DEPTH credits, then one ack per pop
      drive(1'b1, 64'h0, 1'b0, 1'b0);
      check("bp_ack0", 64'(req_ack), 64'd1);
      drive(1'b1, 64'h4, 1'b0, 1'b0);
      check("bp_ack1", 64'(req_ack), 64'd1);
      check_resp("bp_hold0", 32'h1111_1111, 1'b0);
      drive(1'b1, 64'h8, 1'b0, 1'b0);
      check("bp_noack2", 64'(req_ack), 64'd0);
      check_resp("bp_hold1", 32'h1111_1111, 1'b0);
      drive(1'b1, 64'h8, 1'b0, 1'b0);
      check("bp_noack3", 64'(req_ack), 64'd0);
      check_resp("bp_hold2", 32'h1111_1111, 1'b0);
      drive(1'b1, 64'h8, 1'b1, 1'b0);
      check("bp_ack_pop0", 64'(req_ack), 64'd1);
      check_resp("bp_r0", 32'h1111_1111, 1'b0);
      drive(1'b1, 64'hC, 1'b1, 1'b0);
      check("bp_ack_pop1", 64'(req_ack), 64'd1);
      check_resp("bp_r1", 32'h2222_2222, 1'b0);
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      check_resp("bp_r2", 32'h3333_3333, 1'b0);
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      check_resp("bp_r3", 32'h4444_4444, 1'b0);
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      check("bp_idle", 64'(resp_valid), 64'd0);

      // Faults interleaved with good fetches
      drive(1'b1, 64'h0, 1'b1, 1'b0);
      check("flt_rd0", 64'(mem_read), 64'd1);
      drive(1'b1, 64'h102, 1'b1, 1'b0);
      check("flt_ack_mis", 64'(req_ack), 64'd1);
      check("flt_rd_mis", 64'(mem_read), 64'd0);
      check_resp("flt_r0", 32'h1111_1111, 1'b0);
      drive(1'b1, 64'h1000, 1'b1, 1'b0);
      check("flt_ack_oor", 64'(req_ack), 64'd1);
      check("flt_rd_oor", 64'(mem_read), 64'd0);
      check_resp("flt_mis", 32'h0, 1'b1);
      drive(1'b1, 64'h4, 1'b1, 1'b0);
      check("flt_rd1", 64'(mem_read), 64'd1);
      check_resp("flt_oor", 32'h0, 1'b1);
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      check_resp("flt_r1", 32'h2222_2222, 1'b0);
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      check("flt_idle", 64'(resp_valid), 64'd0);

      // Single-cycle flush with two outstanding
      drive(1'b1, 64'h0, 1'b0, 1'b0);
      check("fl_ack0", 64'(req_ack), 64'd1);
      drive(1'b1, 64'h4, 1'b0, 1'b0);
      check("fl_ack1", 64'(req_ack), 64'd1);
      drive(1'b1, 64'h8, 1'b0, 1'b1);
      check("fl_noack", 64'(req_ack), 64'd0);
      check("fl_noread", 64'(mem_read), 64'd0);
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      check("fl_empty", 64'(resp_valid), 64'd0);
      drive(1'b1, 64'h20, 1'b1, 1'b0);
      check("fl_new_ack", 64'(req_ack), 64'd1);
      check("fl_new_addr", 64'(mem_address), 64'h8);
      check("fl_still_empty", 64'(resp_valid), 64'd0);
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      check_resp("fl_new", 32'h8888_8888, 1'b0);
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      check("fl_idle", 64'(resp_valid), 64'd0);

      // Flush held for several cycles
      drive(1'b1, 64'h0, 1'b0, 1'b0);
      check("hf_ack", 64'(req_ack), 64'd1);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 64'h4, 1'b0, 1'b1);
         check("hf_noack", 64'(req_ack), 64'd0);
         if (i > 0) check("hf_empty", 64'(resp_valid), 64'd0);
      end
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      check("hf_after", 64'(resp_valid), 64'd0);

      // Async reset with the FIFO full
      drive(1'b1, 64'h0, 1'b0, 1'b0);
      drive(1'b1, 64'h4, 1'b0, 1'b0);
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      drive(1'b1, 64'h100, 1'b0, 1'b0);
      check("ar_full_valid", 64'(resp_valid), 64'd1);
      check("ar_full_noack", 64'(req_ack), 64'd0);
      rst_n = 1'b0;
      #1;
      check("ar_valid", 64'(resp_valid), 64'd0);
      check("ar_data", 64'(resp_data), 64'd0);
      check("ar_error", 64'(resp_error), 64'd0);
      check("ar_rd", 64'(mem_read), 64'd0);
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      rst_n = 1'b1;
      check("ar_rel_valid", 64'(resp_valid), 64'd0);

      single_fetch("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
